reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// Two-requester register-file writeback arbiter: one-entry buffer per requester,
// oldest-first grant with round-robin tie break, registered write port.
module reg_wb_arbiter (
   input  logic        clk_n,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [2:0]  a_addr,
   input  logic [15:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [2:0]  b_addr,
   input  logic [15:0] b_data,
   output logic        b_ready,
   output logic        wea,
   output logic [2:0]  waddr,
   output logic [15:0] wdata,
   output logic [7:0]  busy_mask,
   output logic [7:0]  drop_cnt
);

   // Requester A buffer
   logic        a_full_q, a_full_d;
   logic        a_old_q, a_old_d;
   logic [2:0]  a_addr_q;
   logic [15:0] a_data_q;

   // Requester B buffer
   logic        b_full_q, b_full_d;
   logic        b_old_q, b_old_d;
   logic [2:0]  b_addr_q;
   logic [15:0] b_data_q;

   // Round-robin pointer: 0 selects A, 1 selects B
   logic        rr_q, rr_d;

   logic        grant_a, grant_b, tie;
   logic        a_load, b_load;
   logic        a_stays, b_stays;
   logic        g_valid;
   logic [2:0]  g_addr;
   logic [15:0] g_data;

   logic        wea_q;
   logic [2:0]  waddr_q;
   logic [15:0] wdata_q;
   logic [7:0]  drop_q;

   // Grant is a pure function of buffer state, so ready never depends on valid.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      tie     = 1'b0;
      if (a_full_q && b_full_q) begin
         if (a_old_q && !b_old_q) begin
            grant_a = 1'b1;
         end else if (b_old_q && !a_old_q) begin
            grant_b = 1'b1;
         end else begin
            tie = 1'b1;
            if (rr_q) begin
               grant_b = 1'b1;
            end else begin
               grant_a = 1'b1;
            end
         end
      end else if (a_full_q) begin
         grant_a = 1'b1;
      end else if (b_full_q) begin
         grant_b = 1'b1;
      end
   end

   assign a_ready = !a_full_q || grant_a;
   assign b_ready = !b_full_q || grant_b;
   assign a_load  = a_valid && a_ready;
   assign b_load  = b_valid && b_ready;

   // A buffer that is full and not granted keeps its entry across the edge.
   assign a_stays = a_full_q && !grant_a;
   assign b_stays = b_full_q && !grant_b;

   always_comb begin
      a_full_d = a_load || a_stays;
      b_full_d = b_load || b_stays;
      // A surviving entry becomes older when the other side loads behind it.
      a_old_d  = a_load ? 1'b0 : (a_stays && (a_old_q || b_load));
      b_old_d  = b_load ? 1'b0 : (b_stays && (b_old_q || a_load));
      rr_d     = tie ? !rr_q : rr_q;
   end

   assign g_valid = grant_a || grant_b;
   assign g_addr  = grant_a ? a_addr_q : b_addr_q;
   assign g_data  = grant_a ? a_data_q : b_data_q;

   always_ff @(posedge clk_n) begin
      if (rst) begin
         a_full_q <= 1'b0;
         a_old_q  <= 1'b0;
         a_addr_q <= 3'd0;
         a_data_q <= 16'd0;
         b_full_q <= 1'b0;
         b_old_q  <= 1'b0;
         b_addr_q <= 3'd0;
         b_data_q <= 16'd0;
         rr_q     <= 1'b0;
      end else begin
         a_full_q <= a_full_d;
         a_old_q  <= a_old_d;
         b_full_q <= b_full_d;
         b_old_q  <= b_old_d;
         rr_q     <= rr_d;
         if (a_load) begin
            a_addr_q <= a_addr;
            a_data_q <= a_data;
         end
         if (b_load) begin
            b_addr_q <= b_addr;
            b_data_q <= b_data;
         end
      end
   end

   // Register-0 writes burn their grant slot but only bump the drop counter.
   always_ff @(posedge clk_n) begin
      if (rst) begin
         wea_q   <= 1'b0;
         waddr_q <= 3'd0;
         wdata_q <= 16'd0;
         drop_q  <= 8'd0;
      end else begin
         wea_q <= g_valid && (g_addr != 3'd0);
         if (g_valid && (g_addr != 3'd0)) begin
            waddr_q <= g_addr;
            wdata_q <= g_data;
         end
         if (g_valid && (g_addr == 3'd0) && (drop_q != 8'hff)) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end

   always_comb begin
      busy_mask = 8'd0;
      for (int i = 1; i < 8; i++) begin
         busy_mask[i] = (a_full_q && (a_addr_q == 3'(i))) ||
                        (b_full_q && (b_addr_q == 3'(i))) ||
                        (wea_q && (waddr_q == 3'(i)));
      end
   end

   assign wea      = wea_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign drop_cnt = drop_q;

endmodule
